digital_lock_lockout: RTL and testbench

//  Parametrised successor to the DigitalLock FSM core, with attempt lockout, entry timeout and

---
 rtl/digital_lock_lockout.sv | 215 +++++++++++++++++++++
 tb/tb_digital_lock_lockout.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_lock_lockout.sv
// Password lock FSM with create/confirm, attempt lockout, entry timeout and masked entry display.
// All outputs are registered from the next-state values.
module digital_lock_lockout #(
  parameter int PASSWORD_LENGTH = 4,
  parameter int NUM_KEYS        = 4,
  parameter int NUM_DISPLAYS    = 6,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int ERROR_CYCLES    = 25000000,
  parameter int LOCKOUT_CYCLES  = 250000000,
  parameter int TIMEOUT_CYCLES  = 250000000,
  parameter int MASK_DIGITS     = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_KEYS-1:0]                   key,
  output logic                                  lock_flag,
  output logic                                  error_flag,
  output logic                                  enter_pwd_flag,
  output logic                                  create_pwd_flag,
  output logic                                  lockout_flag,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attempts_left,
  output logic [4*NUM_DISPLAYS-1:0]             display_digits
);

  localparam int BW   = 4 * PASSWORD_LENGTH;
  localparam int CW   = $clog2(PASSWORD_LENGTH + 1);
  localparam int AW   = $clog2(MAX_ATTEMPTS + 1);
  localparam int TM1  = (ERROR_CYCLES > LOCKOUT_CYCLES) ? ERROR_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX = (TM1 > TIMEOUT_CYCLES) ? TM1 : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] ERR_LAST   = TW'(ERROR_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(PASSWORD_LENGTH - 1);
  localparam logic [AW-1:0] MAX_FAIL   = AW'(MAX_ATTEMPTS);

  if (PASSWORD_LENGTH < 1 || PASSWORD_LENGTH > NUM_DISPLAYS) begin : g_bad_len
    $error("PASSWORD_LENGTH must be within 1..NUM_DISPLAYS");
  end
  if (NUM_KEYS < 2 || NUM_KEYS > 16) begin : g_bad_keys
    $error("NUM_KEYS must be within 2..16");
  end
  if (MAX_ATTEMPTS < 1 || ERROR_CYCLES < 1 || LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 0) begin : g_bad_cnt
    $error("MAX_ATTEMPTS, ERROR_CYCLES and LOCKOUT_CYCLES must be >= 1, TIMEOUT_CYCLES >= 0");
  end

  typedef enum logic [2:0] {
    S_UNLOCKED, S_CREATE, S_CONFIRM, S_LOCKED, S_ENTER, S_ERROR, S_LOCKOUT
  } state_e;

  state_e                    state_q, state_d, ret_q, ret_d;
  logic [BW-1:0]             buf_q, buf_d, cand_q, cand_d, pwd_q, pwd_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [AW-1:0]             fail_q, fail_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      lock_flag_q, lock_flag_d, error_flag_q, error_flag_d;
  logic                      enter_flag_q, enter_flag_d, create_flag_q, create_flag_d;
  logic                      lockout_flag_q, lockout_flag_d;
  logic [AW-1:0]             attempts_q, attempts_d;
  logic [4*NUM_DISPLAYS-1:0] disp_q, disp_d;

  logic                      press;
  logic [3:0]                digit;
  logic [BW-1:0]             shifted;

  always_comb begin
    press = $onehot(key);
    digit = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (key[i]) digit = 4'(i);
    end
    shifted = BW'({buf_q, digit});

    state_d = state_q;
    ret_d   = ret_q;
    buf_d   = buf_q;
    cand_d  = cand_q;
    pwd_d   = pwd_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;

    unique case (state_q)
      S_ERROR: begin
        if (timer_q == ERR_LAST) begin
          state_d = ret_q;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = S_LOCKED;
          fail_d  = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        if (press) begin
          timer_d = '0;
          // UNLOCKED/LOCKED always hold an empty buffer, so they share the digit path
          if (cnt_q == LAST_DIGIT) begin
            buf_d = '0;
            cnt_d = '0;
            if (state_q == S_UNLOCKED || state_q == S_CREATE) begin
              cand_d  = shifted;
              state_d = S_CONFIRM;
            end else if (state_q == S_CONFIRM) begin
              if (shifted == cand_q) begin
                pwd_d   = shifted;
                fail_d  = '0;
                state_d = S_LOCKED;
              end else begin
                state_d = S_ERROR;
                ret_d   = S_UNLOCKED;
              end
            end else if (shifted == pwd_q) begin
              fail_d  = '0;
              state_d = S_UNLOCKED;
            end else begin
              fail_d = fail_q + AW'(1);
              if (fail_d == MAX_FAIL) begin
                state_d = S_LOCKOUT;
              end else begin
                state_d = S_ERROR;
                ret_d   = S_LOCKED;
              end
            end
          end else begin
            buf_d = shifted;
            cnt_d = cnt_q + CW'(1);
            if (state_q == S_UNLOCKED)    state_d = S_CREATE;
            else if (state_q == S_LOCKED) state_d = S_ENTER;
          end
        end else if (TIMEOUT_CYCLES > 0 &&
                     (state_q == S_CREATE || state_q == S_CONFIRM || state_q == S_ENTER)) begin
          if (timer_q == TO_LAST) begin
            buf_d   = '0;
            cnt_d   = '0;
            timer_d = '0;
            state_d = (state_q == S_ENTER) ? S_LOCKED : S_UNLOCKED;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    lock_flag_d    = (state_d == S_LOCKED) || (state_d == S_ENTER);
    error_flag_d   = (state_d == S_ERROR) || (state_d == S_LOCKOUT);
    enter_flag_d   = (state_d == S_ENTER);
    create_flag_d  = (state_d == S_CREATE) || (state_d == S_CONFIRM);
    lockout_flag_d = (state_d == S_LOCKOUT);
    attempts_d     = MAX_FAIL - fail_d;
    disp_d         = '1;
    if (state_d == S_CREATE || state_d == S_CONFIRM || state_d == S_ENTER) begin
      for (int unsigned i = 0; i < PASSWORD_LENGTH; i++) begin
        if (CW'(i) < cnt_d) begin
          disp_d[4*i +: 4] = (MASK_DIGITS != 0 && state_d == S_ENTER) ? 4'hE : buf_d[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_UNLOCKED;
      ret_q          <= S_UNLOCKED;
      buf_q          <= '0;
      cand_q         <= '0;
      pwd_q          <= '0;
      cnt_q          <= '0;
      fail_q         <= '0;
      timer_q        <= '0;
      lock_flag_q    <= 1'b0;
      error_flag_q   <= 1'b0;
      enter_flag_q   <= 1'b0;
      create_flag_q  <= 1'b0;
      lockout_flag_q <= 1'b0;
      attempts_q     <= MAX_FAIL;
      disp_q         <= '1;
    end else begin
      state_q        <= state_d;
      ret_q          <= ret_d;
      buf_q          <= buf_d;
      cand_q         <= cand_d;
      pwd_q          <= pwd_d;
      cnt_q          <= cnt_d;
      fail_q         <= fail_d;
      timer_q        <= timer_d;
      lock_flag_q    <= lock_flag_d;
      error_flag_q   <= error_flag_d;
      enter_flag_q   <= enter_flag_d;
      create_flag_q  <= create_flag_d;
      lockout_flag_q <= lockout_flag_d;
      attempts_q     <= attempts_d;
      disp_q         <= disp_d;
    end
  end

  assign lock_flag       = lock_flag_q;
  assign error_flag      = error_flag_q;
  assign enter_pwd_flag  = enter_flag_q;
  assign create_pwd_flag = create_flag_q;
  assign lockout_flag    = lockout_flag_q;
  assign attempts_left   = attempts_q;
  assign display_digits  = disp_q;

endmodule

// File: tb/tb_digital_lock_lockout.sv
// Bench for digital_lock_lockout: directed scenarios plus random presses, checked every cycle
// against a queue-based behavioural model of the lock.
module tb_digital_lock_lockout;
  localparam int PL = 4, MA = 3, EC = 4, LC = 10, TC = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key = '0;
  logic        lock_flag, error_flag, enter_pwd_flag, create_pwd_flag, lockout_flag;
  logic [1:0]  attempts_left;
  logic [23:0] display_digits;

  int tests = 0;
  int errors = 0;

  always #5 clock = ~clock;

  digital_lock_lockout #(
    .ERROR_CYCLES(EC),
    .LOCKOUT_CYCLES(LC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key(key),
    .lock_flag(lock_flag),
    .error_flag(error_flag),
    .enter_pwd_flag(enter_pwd_flag),
    .create_pwd_flag(create_pwd_flag),
    .lockout_flag(lockout_flag),
    .attempts_left(attempts_left),
    .display_digits(display_digits)
  );

  typedef enum {M_OPEN, M_NEW, M_AGAIN, M_SHUT, M_TRY, M_ERR, M_BAN} mode_t;
  mode_t mode, back;
  int    entry[$];
  int    cand_v, pwd_v, fails, hold, idle;

  function automatic int entry_num();
    int v = 0;
    foreach (entry[i]) v = v * 16 + entry[i];
    return v;
  endfunction

  task automatic model_reset();
    mode = M_OPEN; back = M_OPEN; entry.delete();
    cand_v = 0; pwd_v = 0; fails = 0; hold = 0; idle = 0;
  endtask

  task automatic model_step(input logic [3:0] k);
    bit valid;
    int d, v;
    valid = ($countones(k) == 1);
    d = 0;
    for (int i = 0; i < 4; i++) if (k[i]) d = i;
    case (mode)
      M_ERR: begin hold--; if (hold == 0) mode = back; end
      M_BAN: begin hold--; if (hold == 0) begin mode = M_SHUT; fails = 0; end end
      default: begin
        if (valid) begin
          entry.push_back(d);
          idle = 0;
          if (mode == M_OPEN) mode = M_NEW;
          else if (mode == M_SHUT) mode = M_TRY;
          if (entry.size() == PL) begin
            v = entry_num();
            entry.delete();
            if (mode == M_NEW) begin
              cand_v = v; mode = M_AGAIN;
            end else if (mode == M_AGAIN) begin
              if (v == cand_v) begin pwd_v = v; fails = 0; mode = M_SHUT; end
              else begin mode = M_ERR; back = M_OPEN; hold = EC; end
            end else if (v == pwd_v) begin
              fails = 0; mode = M_OPEN;
            end else begin
              fails++;
              if (fails == MA) begin mode = M_BAN; hold = LC; end
              else begin mode = M_ERR; back = M_SHUT; hold = EC; end
            end
          end
        end else if (mode == M_NEW || mode == M_AGAIN || mode == M_TRY) begin
          idle++;
          if (idle == TC) begin
            idle = 0;
            entry.delete();
            mode = (mode == M_TRY) ? M_SHUT : M_OPEN;
          end
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [23:0] ed;
    ed = '1;
    if (mode == M_NEW || mode == M_AGAIN || mode == M_TRY)
      for (int p = 0; p < entry.size(); p++)
        ed[4*p +: 4] = (mode == M_TRY) ? 4'hE : 4'(entry[entry.size() - 1 - p]);
    check("lock_flag",    32'(lock_flag),       32'(mode == M_SHUT || mode == M_TRY));
    check("error_flag",   32'(error_flag),      32'(mode == M_ERR || mode == M_BAN));
    check("enter_flag",   32'(enter_pwd_flag),  32'(mode == M_TRY));
    check("create_flag",  32'(create_pwd_flag), 32'(mode == M_NEW || mode == M_AGAIN));
    check("lockout_flag", 32'(lockout_flag),    32'(mode == M_BAN));
    check("attempts",     32'(attempts_left),   32'(MA - fails));
    check("display",      32'(display_digits),  32'(ed));
  endtask

  task automatic tick(input logic [3:0] k);
    key = k;
    @(posedge clock);
    model_step(k);
    #1;
    key = '0;
    check_all();
  endtask

  task automatic press(input int d);
    tick(4'(1 << d));
  endtask

  task automatic idle_n(input int n);
    repeat (n) tick('0);
  endtask

  task automatic type_code(input int code);
    for (int j = PL - 1; j >= 0; j--) press((code >> (4 * j)) & 15);
  endtask

  initial begin
    int r;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset = 1'b0;

    // 1: create and confirm 1230
    press(1); press(2); press(3); press(0);
    check("t1_create_mid", 32'(create_pwd_flag), 32'd1);
    press(1); press(2); press(3);
    check("t1_create_last", 32'(create_pwd_flag), 32'd1);
    check("t1_disp_confirm", 32'(display_digits), 32'h00FF_F123);
    press(0);
    check("t1_locked", 32'(lock_flag), 32'd1);
    check("t1_attempts", 32'(attempts_left), 32'd3);

    // 2: unlock with masked entry
    press(1); press(2); press(3);
    check("t2_enter", 32'(enter_pwd_flag), 32'd1);
    check("t2_mask", 32'(display_digits), 32'h00FF_FEEE);
    press(0);
    check("t2_unlocked", 32'(lock_flag), 32'd0);
    check("t2_blank", 32'(display_digits), 32'h00FF_FFFF);

    // 3: three failed tries
    type_code('h1230); type_code('h1230);
    type_code('h0000);
    check("t3_err1", 32'(error_flag), 32'd1);
    check("t3_att2", 32'(attempts_left), 32'd2);
    idle_n(3);
    check("t3_err1_held", 32'(error_flag), 32'd1);
    idle_n(1);
    check("t3_back_locked", 32'(lock_flag), 32'd1);
    type_code('h0000);
    check("t3_att1", 32'(attempts_left), 32'd1);
    idle_n(4);
    type_code('h0000);
    check("t3_lockout", 32'(lockout_flag), 32'd1);
    idle_n(9);
    check("t3_lockout_held", 32'(lockout_flag), 32'd1);
    idle_n(1);
    check("t3_release", 32'(lock_flag), 32'd1);
    check("t3_att_reset", 32'(attempts_left), 32'd3);

    // 4: confirm mismatch
    type_code('h1230);
    type_code('h1230); type_code('h1231);
    check("t4_err", 32'(error_flag), 32'd1);
    idle_n(4);
    check("t4_unlocked", 32'(lock_flag), 32'd0);
    check("t4_noerr", 32'(error_flag), 32'd0);

    // 5: entry timeout
    type_code('h1230); type_code('h1230);
    press(1); press(2);
    idle_n(19);
    check("t5_still_enter", 32'(enter_pwd_flag), 32'd1);
    idle_n(1);
    check("t5_timeout_locked", 32'(lock_flag), 32'd1);
    check("t5_blank", 32'(display_digits), 32'h00FF_FFFF);

    // 6: invalid multi-key press, then reset during lockout
    press(1);
    tick(4'b0011);
    check("t6_ignored", 32'(display_digits), 32'h00FF_FFFE);
    press(0); press(0); press(0);
    idle_n(4);
    type_code('h0000); idle_n(4); type_code('h0000);
    idle_n(3);
    check("t6_in_lockout", 32'(lockout_flag), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_async_flags", 32'({lock_flag, error_flag, enter_pwd_flag, create_pwd_flag, lockout_flag}), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    check_all();
    reset = 1'b0;

    // random phase
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) type_code(pwd_v);
      else if (r < 10) begin
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
        check_all();
        reset = 1'b0;
      end
      else if (r < 50) press($urandom_range(0, 3));
      else if (r < 60) tick(4'($urandom));
      else if (r < 66) idle_n($urandom_range(1, 25));
      else tick('0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
